// File: rtl/sprite_line_fetch.sv
// Sprite line fetch controller: copies one sprite row per horizontal blank into a
// local line buffer, serves registered pixel lookups, and arbitrates the RAM write port.
module sprite_line_fetch #(
    parameter int          SPR_W      = 20,
    parameter int          SPR_H      = 40,
    parameter int          FRAMES     = 4,
    parameter int          ADDR_W     = 19,
    parameter logic [3:0]  TRANSP_IDX = 4'h0
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      line_start,
    input  logic [9:0]                next_y,
    input  logic [9:0]                sprite_x,
    input  logic [9:0]                sprite_y,
    input  logic [$clog2(FRAMES)-1:0] frame_sel,
    input  logic                      flip_h,
    input  logic [9:0]                draw_x,
    output logic [ADDR_W-1:0]         ram_read_addr,
    input  logic [3:0]                ram_data,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_write_addr,
    output logic [3:0]                ram_wdata,
    input  logic                      ld_req,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [3:0]                ld_data,
    output logic                      ld_ack,
    output logic                      pix_on,
    output logic [3:0]                pix_idx,
    output logic                      busy,
    output logic                      overrun
);

    localparam int IDX_W = $clog2(SPR_W);
    localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0] ROW_WORDS   = ADDR_W'(SPR_W);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(SPR_W - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cap_q;
    logic [IDX_W-1:0]  capcnt_q;
    logic              row_valid_q;
    logic              ovr_q;
    logic [9:0]        sx_q;
    logic              flip_q;
    logic              pix_on_q;
    logic [3:0]        pix_idx_q;

    logic [3:0]        linebuf [SPR_W];

    logic [10:0]       row_d;
    logic              row_hit_d;
    logic [ADDR_W-1:0] base_d;
    logic [10:0]       col_d;
    logic              col_hit_d;
    logic [IDX_W-1:0]  col_idx_d;
    logic [3:0]        lb_rd_d;
    logic              pix_hit_d;
    logic [IDX_W-1:0]  wr_idx_d;

    // Row and column offsets are 11-bit two's complement; bit 10 flags "before sprite".
    always_comb begin
        row_d     = {1'b0, next_y} - {1'b0, sprite_y};
        row_hit_d = !row_d[10] && (row_d[9:0] < 10'(SPR_H));
        base_d    = ADDR_W'(frame_sel) * FRAME_WORDS + ADDR_W'(row_d[9:0]) * ROW_WORDS;

        col_d     = {1'b0, draw_x} - {1'b0, sx_q};
        col_hit_d = !col_d[10] && (col_d[9:0] < 10'(SPR_W));
        col_idx_d = col_d[IDX_W-1:0];
        lb_rd_d   = col_hit_d ? linebuf[col_idx_d] : TRANSP_IDX;
        pix_hit_d = row_valid_q && col_hit_d && (lb_rd_d != TRANSP_IDX);

        wr_idx_d  = flip_q ? (LAST_IDX - capcnt_q) : capcnt_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            cap_q       <= 1'b0;
            capcnt_q    <= '0;
            row_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
            sx_q        <= '0;
            flip_q      <= 1'b0;
        end else begin
            // Read data lags the address by one cycle, so the buffer write index lags too.
            cap_q    <= (state_q == FETCH);
            capcnt_q <= cnt_q;
            if (line_start && state_q != IDLE) begin
                ovr_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (line_start) begin
                        sx_q        <= sprite_x;
                        flip_q      <= flip_h;
                        row_valid_q <= 1'b0;
                        if (row_hit_d) begin
                            addr_q  <= base_d;
                            cnt_q   <= '0;
                            state_q <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= DRAIN;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    row_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (cap_q) begin
            linebuf[wr_idx_d] <= ram_data;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pix_on_q  <= 1'b0;
            pix_idx_q <= '0;
        end else begin
            pix_on_q  <= pix_hit_d;
            pix_idx_q <= pix_hit_d ? lb_rd_d : '0;
        end
    end

    assign ld_ack         = ld_req && (state_q == IDLE) && !line_start;
    assign ram_we         = ld_ack;
    assign ram_write_addr = ld_addr;
    assign ram_wdata      = ld_data;
    assign ram_read_addr  = addr_q;
    assign busy           = (state_q != IDLE);
    assign overrun        = ovr_q;
    assign pix_on         = pix_on_q;
    assign pix_idx        = pix_idx_q;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Bench for sprite_line_fetch: behavioural RAM and row/pixel model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sprite_line_fetch;

    localparam int SPR_W  = 20;
    localparam int SPR_H  = 40;
    localparam int FRAMES = 4;
    localparam int ADDR_W = 19;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              line_start = 1'b0;
    logic [9:0]        next_y = '0, sprite_x = '0, sprite_y = '0, draw_x = '0;
    logic [1:0]        frame_sel = '0;
    logic              flip_h = 1'b0;
    logic [ADDR_W-1:0] ram_read_addr, ram_write_addr;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [3:0]        ram_data = '0, ram_wdata, pix_idx;
    logic [3:0]        ld_data = '0;
    logic              ram_we, ld_ack, pix_on, busy, overrun;
    logic              ld_req = 1'b0;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [3:0] mem [0:4095];

    sprite_line_fetch #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .ADDR_W(ADDR_W), .TRANSP_IDX(4'h0)
    ) dut (
        .CLK(CLK), .RESET(RESET), .line_start(line_start), .next_y(next_y),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .frame_sel(frame_sel), .flip_h(flip_h),
        .draw_x(draw_x), .ram_read_addr(ram_read_addr), .ram_data(ram_data),
        .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_wdata(ram_wdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
        .pix_on(pix_on), .pix_idx(pix_idx), .busy(busy), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    // Sprite RAM: synchronous read, one cycle latency.
    always @(posedge CLK) begin
        if (ram_we) mem[ram_write_addr[11:0]] <= ram_wdata;
        ram_data <= mem[ram_read_addr[11:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch accepted at an edge snapshots the row straight from RAM,
    // stays busy for SPR_W+1 cycles, then publishes the row.
    int         m_busy_left = 0;
    int         m_base = 0;
    int         m_sx = 0;
    int         m_row, m_col;
    bit         m_rv = 1'b0, m_ovr = 1'b0, e_on = 1'b0, was_busy;
    logic [3:0] e_idx = '0;
    logic [3:0] m_lb [SPR_W];
    logic [3:0] m_pend [SPR_W];

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_busy_left = 0; m_rv = 1'b0; m_ovr = 1'b0; e_on = 1'b0; e_idx = '0; m_base = 0;
        end else begin
            m_col = int'(draw_x) - m_sx;
            e_on = 1'b0; e_idx = '0;
            if (m_rv && m_col >= 0 && m_col < SPR_W && m_lb[m_col] != 4'h0) begin
                e_on = 1'b1; e_idx = m_lb[m_col];
            end
            was_busy = (m_busy_left > 0);
            if (was_busy) begin
                m_busy_left--;
                if (m_busy_left == 0) begin m_rv = 1'b1; m_lb = m_pend; end
            end
            if (line_start) begin
                if (was_busy) m_ovr = 1'b1;
                else begin
                    m_sx = int'(sprite_x);
                    m_rv = 1'b0;
                    m_row = int'(next_y) - int'(sprite_y);
                    if (m_row >= 0 && m_row < SPR_H) begin
                        m_base = int'(frame_sel) * SPR_W * SPR_H + m_row * SPR_W;
                        for (int i = 0; i < SPR_W; i++)
                            m_pend[flip_h ? SPR_W - 1 - i : i] = mem[(m_base + i) % 4096];
                        m_busy_left = SPR_W + 1;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            logic exp_ack;
            exp_ack = ld_req && (m_busy_left == 0) && !line_start;
            chk("busy", 32'(busy), 32'(m_busy_left > 0));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("pix_on", 32'(pix_on), 32'(e_on));
            chk("pix_idx", 32'(pix_idx), 32'(e_idx));
            chk("ld_ack", 32'(ld_ack), 32'(exp_ack));
            chk("ram_we", 32'(ram_we), 32'(exp_ack));
            if (exp_ack) begin
                chk("wr_addr", 32'(ram_write_addr), 32'(ld_addr));
                chk("wr_data", 32'(ram_wdata), 32'(ld_data));
            end
            if (m_busy_left >= 2)
                chk("rd_addr", 32'(ram_read_addr), 32'(m_base + SPR_W + 1 - m_busy_left));
            if (RESET) chk("rd_addr_rst", 32'(ram_read_addr), 32'd0);
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic start_line(input int ny, input int sy, input int sx, input int fs, input bit fl);
        next_y = 10'(ny); sprite_y = 10'(sy); sprite_x = 10'(sx);
        frame_sel = 2'(fs); flip_h = fl; line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic sweep(input int sx);
        for (int c = -3; c <= SPR_W + 3; c++) begin
            draw_x = 10'(sx + c);
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, ack_cnt;
        bit ack_seen;
        for (int i = 0; i < 4096; i++) mem[i] <= 4'(i & 15);

        @(negedge CLK);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_pix_on", 32'(pix_on), 32'd0);
        chk("rst_pix_idx", 32'(pix_idx), 32'd0);
        chk("rst_rd_addr", 32'(ram_read_addr), 32'd0);
        chk("rst_ld_ack", 32'(ld_ack), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk_en = 1'b1;
        tick();

        // Frame 0, row 5, no mirror: addresses 100..119, busy for 21 cycles.
        start_line(105, 100, 50, 0, 1'b0);
        busy_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge CLK);
            if (busy) busy_cnt++;
            if (k == 0)  chk("addr_first", 32'(ram_read_addr), 32'd100);
            if (k == 19) chk("addr_last", 32'(ram_read_addr), 32'd119);
        end
        chk("busy_len", 32'(busy_cnt), 32'd21);
        tick();
        sweep(50);

        // Frame 2, mirrored: linebuf[19-i] = (1700+i)&0xF.
        start_line(105, 100, 50, 2, 1'b1);
        repeat (23) tick();
        draw_x = 10'(50 + 19); tick(); @(negedge CLK);
        chk("flip_idx19", 32'(pix_idx), 32'd4);
        chk("flip_on19", 32'(pix_on), 32'd1);
        tick();
        draw_x = 10'(50 + 7); tick(); @(negedge CLK);
        chk("transp_on", 32'(pix_on), 32'd0);
        chk("transp_idx", 32'(pix_idx), 32'd0);
        tick();
        draw_x = 10'(49); tick(); @(negedge CLK);
        chk("left_edge_on", 32'(pix_on), 32'd0);
        tick();
        draw_x = 10'(70); tick(); @(negedge CLK);
        chk("right_edge_on", 32'(pix_on), 32'd0);
        tick();
        sweep(50);

        // Rows just outside the sprite: no fetch.
        start_line(99, 100, 60, 1, 1'b0);
        repeat (3) tick();
        @(negedge CLK); chk("above_busy", 32'(busy), 32'd0);
        tick(); sweep(60);
        start_line(140, 100, 60, 1, 1'b0);
        repeat (3) tick();
        @(negedge CLK); chk("below_busy", 32'(busy), 32'd0);
        tick(); sweep(60);

        // Loader held across a fetch.
        ld_req = 1'b1; ld_addr = 19'd3001; ld_data = 4'h9;
        tick();
        ld_addr = 19'd3002; ld_data = 4'hA;
        next_y = 10'd110; sprite_y = 10'd100; sprite_x = 10'd30; frame_sel = 2'd1; flip_h = 1'b0;
        line_start = 1'b1;
        @(negedge CLK); chk("ld_block_ls", 32'(ld_ack), 32'd0);
        tick();
        line_start = 1'b0;
        ack_cnt = 0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge CLK);
            if (ld_ack || ram_we) ack_cnt++;
        end
        chk("ld_block_fetch", 32'(ack_cnt), 32'd0);
        @(negedge CLK);
        chk("ld_grant", 32'(ld_ack), 32'd1);
        chk("ld_grant_addr", 32'(ram_write_addr), 32'd3002);
        chk("ld_grant_data", 32'(ram_wdata), 32'hA);
        tick();
        ld_req = 1'b0;
        sweep(30);

        // Overrun: second line_start 5 cycles into a fetch.
        start_line(120, 100, 80, 3, 1'b1);
        repeat (4) tick();
        start_line(101, 100, 200, 0, 1'b0);
        @(negedge CLK); chk("overrun_set", 32'(overrun), 32'd1);
        tick();
        repeat (20) tick();
        @(negedge CLK); chk("overrun_sticky", 32'(overrun), 32'd1);
        tick();
        sweep(80);
        RESET = 1'b1;
        @(negedge CLK); chk("overrun_clr", 32'(overrun), 32'd0);
        tick();
        RESET = 1'b0;
        tick();

        // Reset mid-fetch discards the partial row.
        start_line(103, 100, 40, 1, 1'b0);
        repeat (8) tick();
        RESET = 1'b1;
        @(negedge CLK);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_addr", 32'(ram_read_addr), 32'd0);
        tick();
        RESET = 1'b0;
        sweep(40);

        // Randomized traffic.
        ack_seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!ld_req || ack_seen) begin
                ld_req  = ($urandom_range(0, 2) == 0);
                ld_addr = ADDR_W'($urandom_range(0, 4095));
                ld_data = 4'($urandom);
            end
            draw_x = 10'(m_sx + int'($urandom_range(0, SPR_W + 6)) - 3);
            line_start = ($urandom_range(0, 29) == 0);
            if (line_start) begin
                sprite_y  = 10'($urandom);
                next_y    = 10'(int'(sprite_y) + int'($urandom_range(0, SPR_H + 5)) - 2);
                sprite_x  = 10'($urandom_range(0, 1000));
                frame_sel = 2'($urandom);
                flip_h    = 1'($urandom);
            end
            @(negedge CLK);
            ack_seen = ld_ack;
            tick();
        end
        line_start = 1'b0;
        ld_req = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_line_fetch.md
# sprite_line_fetch

Sprite line fetch controller for the on-chip sprite RAM: 4-bit colour indices, 19-bit addresses, synchronous read with 1-cycle latency, separate read and write ports. The controller sits between the VGA timing logic and one sprite RAM instance.

- During each horizontal blank it sequences the RAM read port to copy the sprite row for the upcoming scanline into a local line buffer. The row comes from the selected animation frame and is optionally mirrored.
- During active video it serves registered pixel lookups from that line buffer.
- It arbitrates the RAM write port for a loader client, which may write only while no row fetch is in progress.

## Interface
Parameters:
- SPR_W, 20: sprite width in pixels.
- SPR_H, 40: sprite height in pixels.
- FRAMES, 4: number of animation frames stored back to back in RAM, each SPR_W*SPR_H entries.
- ADDR_W, 19: RAM address width.
- TRANSP_IDX, 4'h0: colour index treated as transparent.

Ports:
- CLK  in  1  system clock. All logic is on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- line_start  in  1  one-cycle pulse at the start of horizontal blank.
- next_y  in  10  scanline number of the upcoming line. Sampled on line_start.
- sprite_x  in  10  sprite left column. Sampled on line_start.
- sprite_y  in  10  sprite top row. Sampled on line_start.
- frame_sel  in  $clog2(FRAMES)  animation frame. Sampled on line_start.
- flip_h  in  1  horizontal mirror. Sampled on line_start.
- draw_x  in  10  current active-video column.
- ram_read_addr  out  ADDR_W  RAM read address.
- ram_data  in  4  RAM read data. Valid 1 cycle after ram_read_addr.
- ram_we  out  1  RAM write enable.
- ram_write_addr  out  ADDR_W  RAM write address.
- ram_wdata  out  4  RAM write data.
- ld_req  in  1  loader write request. Held until ld_ack.
- ld_addr  in  ADDR_W  loader write address.
- ld_data  in  4  loader write data.
- ld_ack  out  1  loader grant. The write occurs in the same cycle.
- pix_on  out  1  sprite pixel visible at the registered draw_x.
- pix_idx  out  4  colour index. 0 when pix_on=0.
- busy  out  1  high while in FETCH or DRAIN.
- overrun  out  1  sticky error flag: set when line_start arrives while busy.

## Operation
- States: IDLE, FETCH, DRAIN.

IDLE, on line_start:
- Latch sprite_x, frame_sel and flip_h.
- Compute row = next_y − sprite_y as an 11-bit two's-complement value.
- If 0 ≤ row < SPR_H:
  - Set base = frame_sel*SPR_W*SPR_H + row*SPR_W, computed in ADDR_W bits.
  - Clear cnt and row_valid.
  - Go to FETCH.
- Otherwise clear row_valid and stay in IDLE.

FETCH:
- ram_read_addr = base + cnt; cnt increments each cycle.
- The data returned one cycle later is written to linebuf[flip ? SPR_W−1−cnt_d : cnt_d], where cnt_d is cnt delayed one cycle.
- After cnt = SPR_W−1 is issued, go to DRAIN.

DRAIN:
- Capture the last word.
- Set row_valid = 1.
- Go to IDLE.

Line_start while busy:
- Ignored.
- overrun is set and stays set until RESET.
- The fetch in progress completes normally.

Loader arbitration:
- ld_ack = ram_we = ld_req && state == IDLE && !line_start. This is combinational; row fetch has priority.
- ram_write_addr and ram_wdata pass through ld_addr and ld_data.
- A loader holding ld_req across a fetch is granted in the first IDLE cycle without line_start.

Pixel path, registered:
- col = draw_x − latched sprite_x, 11-bit.
- hit = row_valid && 0 ≤ col < SPR_W && linebuf[col] != TRANSP_IDX.
- pix_on <= hit; pix_idx <= hit ? linebuf[col] : 0.

Line buffer:
- linebuf is not reset; row_valid gates all reads of it.

## Timing
- Reset values: state IDLE, row_valid 0, busy 0, overrun 0, pix_on 0, pix_idx 0, ram_read_addr 0. ram_we and ld_ack are 0 because state is IDLE and ld_req is low.
- Fetch occupancy: line_start at cycle t puts the FSM in FETCH from t+1. It issues addresses on cycles t+1..t+SPR_W and is in DRAIN at t+SPR_W+1. row_valid and busy=0 take effect at t+SPR_W+2, so busy lasts SPR_W+1 cycles.
- The horizontal blank must exceed SPR_W+2 cycles; the 640x480 blank of 160 cycles satisfies this.
- Pixel latency: 1 cycle from draw_x to pix_on/pix_idx.
- Loader throughput: one write per cycle while IDLE and ld_req is held with new data after each ack.
- Reset asserted mid-fetch: return to IDLE immediately and discard the partial row; row_valid=0.

## Test plan
- Reset, then line_start with next_y=sprite_y+5, frame_sel=0, flip_h=0 → read addresses 100..119 on consecutive cycles, busy high for 21 cycles, row_valid then 1.
- Same row with frame_sel=2 and flip_h=1, RAM preloaded with addr&0xF → linebuf[19−i] = (1700+i)&0xF. draw_x=sprite_x+19 gives pix_idx=(1700)&0xF one cycle later.
- next_y=sprite_y−1 and next_y=sprite_y+40 → no fetch, busy stays 0, pix_on=0 for every draw_x.
- Linebuf entry equal to TRANSP_IDX, and draw_x = sprite_x−1 and sprite_x+20 → pix_on=0, pix_idx=0.
- ld_req held from cycle t−1 with line_start at t → ld_ack=0 and ram_we=0 through DRAIN, then ld_ack=1 at t+SPR_W+2 with write address and data equal to ld_addr and ld_data.
- Second line_start at t+5 during a fetch → overrun=1 and stays set. The original fetch completes with correct linebuf contents; RESET clears overrun.
